// File: rtl/cla_addsub_pipe_if.sv
// Operand/result stream bundle for the pipelined CLA adder/subtractor.
// The slave modport is the adder's side; master is the producer/consumer side.
interface cla_addsub_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf, zero
    );
endinterface

// File: rtl/cla_addsub_pipe.sv
// Two-stage carry-lookahead adder/subtractor with a valid/ready stream.
// Stage 1 holds bit/group generate-propagate terms; stage 2 holds sum and flags.
module cla_addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input logic           clk,
    input logic           rst,
    cla_addsub_pipe_if.slave bus
);
    localparam int NG = WIDTH / GROUP;

    generate
        if (((WIDTH % GROUP) != 0) || (WIDTH < 4) ||
            !((GROUP == 2) || (GROUP == 4) || (GROUP == 8))) begin : g_bad_params
            $error("cla_addsub_pipe: illegal WIDTH/GROUP combination");
        end
    endgenerate

    logic                          adv1_s, adv2_s;
    logic [WIDTH-1:0]              b_eff_s, g_s, p_s;
    logic                          cin_eff_s;
    logic [NG-1:0]                 gg_s, gp_s;
    logic [NG-1:0][GROUP-2:0]      gl_s;

    logic                          v1_r;
    logic [WIDTH-1:0]              p_r;
    logic [NG-1:0][GROUP-2:0]      gl_r;
    logic [NG-1:0]                 gg_r, gp_r;
    logic                          c0_r;

    logic [NG:0]                   gc_s;
    logic [WIDTH-1:0]              c_s, sum_s;
    logic                          cout_s, ovf_s, zero_s;

    logic                          v2_r;
    logic [WIDTH-1:0]              s_r;
    logic                          cout_r, ovf_r, zero_r;

    // Pipeline advance: a stage may load when it is empty or its successor moves
    always_comb begin
        adv2_s = ~v2_r | bus.out_ready;
        adv1_s = ~v1_r | adv2_s;
    end

    assign bus.in_ready  = adv1_s;
    assign bus.out_valid = v2_r;
    assign bus.s         = s_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
    assign bus.zero      = zero_r;

    // Stage 1 logic: operand inversion for subtract, bit and group G/P terms
    always_comb begin
        logic gacc, pacc;
        gacc      = 1'b0;
        pacc      = 1'b1;
        b_eff_s   = bus.sub ? ~bus.b : bus.b;
        cin_eff_s = bus.sub ? ~bus.cin : bus.cin;
        g_s       = bus.a & b_eff_s;
        p_s       = bus.a ^ b_eff_s;
        gg_s      = '0;
        gp_s      = '0;
        gl_s      = '0;
        for (int k = 0; k < NG; k++) begin
            gacc = 1'b0;
            pacc = 1'b1;
            for (int j = 0; j < GROUP; j++) begin
                gacc = g_s[k*GROUP+j] | (p_s[k*GROUP+j] & gacc);
                pacc = pacc & p_s[k*GROUP+j];
            end
            gg_s[k] = gacc;
            gp_s[k] = pacc;
            // The top generate bit of each group only feeds the group term
            for (int m = 0; m < GROUP - 1; m++) begin
                gl_s[k][m] = g_s[k*GROUP+m];
            end
        end
    end

    // Stage 1 register bank
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r <= 1'b0;
            p_r  <= '0;
            gl_r <= '0;
            gg_r <= '0;
            gp_r <= '0;
            c0_r <= 1'b0;
        end else if (adv1_s) begin
            v1_r <= bus.in_valid;
            p_r  <= p_s;
            gl_r <= gl_s;
            gg_r <= gg_s;
            gp_r <= gp_s;
            c0_r <= cin_eff_s;
        end
    end

    // Stage 2 logic: every carry is an independent sum of products, no ripple
    always_comb begin
        logic acc, prod;
        acc   = 1'b0;
        prod  = 1'b1;
        gc_s  = '0;
        c_s   = '0;
        gc_s[0] = c0_r;
        for (int k = 1; k <= NG; k++) begin
            acc  = 1'b0;
            prod = 1'b1;
            for (int j = k - 1; j >= 0; j--) begin
                acc  = acc | (gg_r[j] & prod);
                prod = prod & gp_r[j];
            end
            gc_s[k] = acc | (c0_r & prod);
        end
        for (int k = 0; k < NG; k++) begin
            for (int m = 0; m < GROUP; m++) begin
                acc  = 1'b0;
                prod = 1'b1;
                for (int j = m - 1; j >= 0; j--) begin
                    acc  = acc | (gl_r[k][j] & prod);
                    prod = prod & p_r[k*GROUP+j];
                end
                c_s[k*GROUP+m] = acc | (gc_s[k] & prod);
            end
        end
        sum_s  = p_r ^ c_s;
        cout_s = gc_s[NG];
        ovf_s  = c_s[WIDTH-1] ^ cout_s;
        zero_s = (sum_s == '0);
    end

    // Stage 2 result register; holds while stalled downstream
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_r   <= 1'b0;
            s_r    <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else if (adv2_s) begin
            v2_r   <= v1_r;
            s_r    <= sum_s;
            cout_r <= cout_s;
            ovf_r  <= ovf_s;
            zero_r <= zero_s;
        end
    end
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Bench for cla_addsub_pipe: directed cases on 16/4, randomized streams on
// 16/8 and 32/4 against an arithmetic model of a +/- b +/- cin.
module tb_cla_addsub_pipe;
    localparam int N_TXN = 10000;

    typedef struct {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cla_addsub_pipe_if #(.WIDTH(16)) bus0 ();
    cla_addsub_pipe_if #(.WIDTH(16)) bus1 ();
    cla_addsub_pipe_if #(.WIDTH(32)) bus2 ();

    cla_addsub_pipe #(.WIDTH(16), .GROUP(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    cla_addsub_pipe #(.WIDTH(16), .GROUP(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    cla_addsub_pipe #(.WIDTH(32), .GROUP(4)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        exp_t   e;
        longint m, ua, ub, sa, sb, ci, r, sr;
        m  = longint'(1) << w;
        ua = longint'(a);
        ub = longint'(b);
        ci = cin ? longint'(1) : longint'(0);
        sa = a[w-1] ? ua - m : ua;
        sb = b[w-1] ? ub - m : ub;
        if (sub) begin
            r      = ua - ub - ci;
            sr     = sa - sb - ci;
            e.cout = (ua >= ub + ci);
        end else begin
            r      = ua + ub + ci;
            sr     = sa + sb + ci;
            e.cout = (r >= m);
        end
        e.s    = 32'(r & (m - 1));
        e.ovf  = (sr < -(m / 2)) || (sr >= (m / 2));
        e.zero = (e.s == 32'd0);
        return e;
    endfunction

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input logic [15:0] es,
                          input logic ec, input logic eo, input logic ez);
        bus0.a = a; bus0.b = b; bus0.cin = cin; bus0.sub = sub;
        bus0.in_valid = 1'b1; bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        chk({tag, "_lat1"}, bus0.out_valid, 1'b0);
        @(posedge clk); #1;
        chk({tag, "_valid"}, bus0.out_valid, 1'b1);
        chk({tag, "_s"},     bus0.s,    es);
        chk({tag, "_cout"},  bus0.cout, ec);
        chk({tag, "_ovf"},   bus0.ovf,  eo);
        chk({tag, "_zero"},  bus0.zero, ez);
        @(posedge clk); #1;
    endtask

    exp_t        q1[$], q2[$];
    exp_t        e;
    int          sent1, sent2, got1, got2;
    logic        hold1, hold2;
    logic [31:0] prev1, prev2;

    initial begin
        rst = 1'b1;
        bus0.in_valid = 1'b0; bus0.out_ready = 1'b1; bus0.a = '0; bus0.b = '0; bus0.cin = 1'b0; bus0.sub = 1'b0;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b1; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.sub = 1'b0;
        bus2.in_valid = 1'b0; bus2.out_ready = 1'b1; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0; bus2.sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", bus0.out_valid, 1'b0);
        chk("rst_in_ready",  bus0.in_ready,  1'b1);
        chk("rst_s",         bus0.s,         16'h0000);
        chk("rst_cout",      bus0.cout,      1'b0);
        chk("rst_ovf",       bus0.ovf,       1'b0);
        chk("rst_zero",      bus0.zero,      1'b0);

        run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op("add_cin",  16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0);
        run_op("sub_neg",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);

        // Three back-to-back ops into a stalled consumer
        bus0.out_ready = 1'b0;
        bus0.a = 16'h1111; bus0.b = 16'h2222; bus0.cin = 1'b0; bus0.sub = 1'b0; bus0.in_valid = 1'b1;
        #1 chk("stall_rdy0", bus0.in_ready, 1'b1);
        @(posedge clk); #1;
        bus0.a = 16'hA000; bus0.b = 16'h0001; bus0.cin = 1'b0; bus0.sub = 1'b1;
        #1 chk("stall_rdy1", bus0.in_ready, 1'b1);
        @(posedge clk); #1;
        bus0.a = 16'hFFFF; bus0.b = 16'hFFFF; bus0.cin = 1'b1; bus0.sub = 1'b0;
        #1;
        chk("stall_full_rdy", bus0.in_ready,  1'b0);
        chk("stall_valid",    bus0.out_valid, 1'b1);
        chk("stall_s1",       bus0.s,         16'h3333);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_hold_s",   bus0.s,         16'h3333);
            chk("stall_hold_v",   bus0.out_valid, 1'b1);
            chk("stall_hold_rdy", bus0.in_ready,  1'b0);
        end
        bus0.out_ready = 1'b1;
        #1 chk("stall_release_rdy", bus0.in_ready, 1'b1);
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        chk("drain_v2",    bus0.out_valid, 1'b1);
        chk("drain_s2",    bus0.s,         16'h9FFF);
        chk("drain_c2",    bus0.cout,      1'b1);
        @(posedge clk); #1;
        chk("drain_v3",    bus0.out_valid, 1'b1);
        chk("drain_s3",    bus0.s,         16'hFFFF);
        chk("drain_c3",    bus0.cout,      1'b1);
        @(posedge clk); #1;
        chk("drain_empty", bus0.out_valid, 1'b0);

        // Reset with both stages occupied
        bus0.out_ready = 1'b0;
        bus0.a = 16'h0001; bus0.b = 16'h0001; bus0.cin = 1'b0; bus0.sub = 1'b0; bus0.in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_valid", bus0.out_valid, 1'b1);
        rst = 1'b1;
        bus0.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_valid", bus0.out_valid, 1'b0);
        chk("mid_rst_rdy",   bus0.in_ready,  1'b1);
        chk("mid_rst_s",     bus0.s,         16'h0000);
        chk("mid_rst_cout",  bus0.cout,      1'b0);
        bus0.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("no_stale", bus0.out_valid, 1'b0);
        end

        // Randomized streams on both alternate configurations
        sent1 = 0; sent2 = 0; got1 = 0; got2 = 0;
        hold1 = 1'b0; hold2 = 1'b0; prev1 = '0; prev2 = '0;
        for (int cyc = 0; cyc < 60000 && (got1 < N_TXN || got2 < N_TXN); cyc++) begin
            bus1.in_valid  = (sent1 < N_TXN) && ($urandom_range(0, 3) != 0);
            bus1.a         = 16'($urandom);
            bus1.b         = 16'($urandom);
            bus1.cin       = 1'($urandom);
            bus1.sub       = 1'($urandom);
            bus1.out_ready = ($urandom_range(0, 3) != 0);
            bus2.in_valid  = (sent2 < N_TXN) && ($urandom_range(0, 3) != 0);
            bus2.a         = $urandom;
            bus2.b         = $urandom;
            bus2.cin       = 1'($urandom);
            bus2.sub       = 1'($urandom);
            bus2.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (hold1) begin
                chk("w16_hold_v", bus1.out_valid, 1'b1);
                chk("w16_hold_s", bus1.s, prev1);
            end
            if (hold2) begin
                chk("w32_hold_v", bus2.out_valid, 1'b1);
                chk("w32_hold_s", bus2.s, prev2);
            end
            if (bus1.in_valid && bus1.in_ready) begin
                q1.push_back(model(16, 32'(bus1.a), 32'(bus1.b), bus1.cin, bus1.sub));
                sent1++;
            end
            if (bus2.in_valid && bus2.in_ready) begin
                q2.push_back(model(32, bus2.a, bus2.b, bus2.cin, bus2.sub));
                sent2++;
            end
            if (bus1.out_valid && bus1.out_ready) begin
                if (q1.size() == 0) begin
                    checks++; failures++;
                    $error("FAIL w16_spurious observed=result expected=none");
                end else begin
                    e = q1.pop_front();
                    chk("w16_s",    bus1.s,    e.s);
                    chk("w16_cout", bus1.cout, e.cout);
                    chk("w16_ovf",  bus1.ovf,  e.ovf);
                    chk("w16_zero", bus1.zero, e.zero);
                    got1++;
                end
            end
            if (bus2.out_valid && bus2.out_ready) begin
                if (q2.size() == 0) begin
                    checks++; failures++;
                    $error("FAIL w32_spurious observed=result expected=none");
                end else begin
                    e = q2.pop_front();
                    chk("w32_s",    bus2.s,    e.s);
                    chk("w32_cout", bus2.cout, e.cout);
                    chk("w32_ovf",  bus2.ovf,  e.ovf);
                    chk("w32_zero", bus2.zero, e.zero);
                    got2++;
                end
            end
            hold1 = bus1.out_valid && !bus1.out_ready;
            hold2 = bus2.out_valid && !bus2.out_ready;
            prev1 = 32'(bus1.s);
            prev2 = bus2.s;
            @(posedge clk); #1;
        end
        chk("w16_count",  got1, N_TXN);
        chk("w32_count",  got2, N_TXN);
        chk("w16_qempty", q1.size(), 0);
        chk("w32_qempty", q2.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
